sram_dp_core: RTL and testbench

//  Parametrised simple-dual-port SRAM: one write port, one read port, both on the same clock.

---
 rtl/sram_pkg.sv | 15 +
 rtl/sram_init_fsm.sv | 60 ++++++
 rtl/sram_dp_core.sv | 118 +++++++++++
 tb/tb_sram_dp_core.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared types for the simple-dual-port SRAM.
// Read-during-write mode and clear-engine states.
package sram_pkg;

    typedef enum logic {
        RDW_OLD,
        RDW_NEW
    } rdw_mode_e;

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } sram_state_e;

endpackage

// File: rtl/sram_init_fsm.sv
// Clear engine for the SRAM array.
// Walks every word writing zero after reset or on request.
module sram_init_fsm
    import sram_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          init_req,
    output logic          busy,
    output logic [CW-1:0] clr_addr,
    output logic          clr_we
);

    localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

    sram_state_e   st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // State and clear counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q  <= ST_CLEAR;
            cnt_q <= '0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
        end
    end

    // Next-state: sweep all words, then idle until a new request
    always_comb begin
        st_d     = st_q;
        cnt_d    = cnt_q;
        busy     = 1'b0;
        clr_we   = 1'b0;
        clr_addr = cnt_q;
        unique case (st_q)
            ST_CLEAR: begin
                busy   = 1'b1;
                clr_we = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    st_d  = ST_READY;
                    cnt_d = '0;
                end
            end
            ST_READY: begin
                if (init_req) begin
                    st_d  = ST_CLEAR;
                    cnt_d = '0;
                end
            end
            default: st_d = ST_CLEAR;
        endcase
    end

endmodule

// File: rtl/sram_dp_core.sv
// Simple-dual-port SRAM with byte enables, selectable
// read-during-write, optional output register and clear engine.
module sram_dp_core
    import sram_pkg::*;
#(
    parameter int        DATA_W   = 32,
    parameter int        ADDR_W   = 4,
    parameter int        DEPTH    = 1 << ADDR_W,
    parameter rdw_mode_e RDW_MODE = RDW_OLD,
    parameter int        OUT_REG  = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                init_req,
    output logic                busy,
    input  logic                we,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wbe,
    input  logic                re,
    input  logic [ADDR_W-1:0]   raddr,
    output logic [DATA_W-1:0]   rdata,
    output logic                rvalid
);

    localparam int NB = DATA_W / 8;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic          clr_we;
    logic [IW-1:0] clr_addr;
    logic          w_in, r_in, wr_ok, rd_ok, byp;
    logic [IW-1:0] widx, ridx;
    logic [DATA_W-1:0] rd_word, rd_val;
    logic [DATA_W-1:0] r1_data_q;
    logic              r1_valid_q;

    sram_init_fsm #(
        .DEPTH (DEPTH),
        .CW    (IW)
    ) u_init (
        .clk      (clk),
        .rst_n    (rst_n),
        .init_req (init_req),
        .busy     (busy),
        .clr_addr (clr_addr),
        .clr_we   (clr_we)
    );

    assign w_in  = ({1'b0, waddr} < DEPTH_L);
    assign r_in  = ({1'b0, raddr} < DEPTH_L);
    assign widx  = waddr[IW-1:0];
    assign ridx  = raddr[IW-1:0];
    assign wr_ok = !busy && we && w_in;
    assign rd_ok = !busy && re;
    assign byp   = (RDW_MODE == RDW_NEW) && wr_ok
                && (waddr == raddr);

    // Array write: clear engine has priority, user writes per byte lane
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_ok) begin
            for (int i = 0; i < NB; i++) begin
                if (wbe[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Read word with optional write-data bypass on same-address collision
    always_comb begin
        rd_word = r_in ? mem[ridx] : '0;
        rd_val  = rd_word;
        if (byp) begin
            for (int i = 0; i < NB; i++) begin
                if (wbe[i]) rd_val[8*i +: 8] = wdata[8*i +: 8];
            end
        end
    end

    // First read stage; data held when no read is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_data_q  <= '0;
            r1_valid_q <= 1'b0;
        end else begin
            r1_valid_q <= rd_ok;
            if (rd_ok) r1_data_q <= rd_val;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [DATA_W-1:0] r2_data_q;
            logic              r2_valid_q;

            // Optional output register adds one cycle of latency
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r2_data_q  <= '0;
                    r2_valid_q <= 1'b0;
                end else begin
                    r2_valid_q <= r1_valid_q;
                    if (r1_valid_q) r2_data_q <= r1_data_q;
                end
            end

            assign rdata  = r2_data_q;
            assign rvalid = r2_valid_q;
        end else begin : g_noreg
            assign rdata  = r1_data_q;
            assign rvalid = r1_valid_q;
        end
    endgenerate

endmodule

// File: tb/tb_sram_dp_core.sv
// Bench for sram_dp_core: three instances (old/no-oreg/16,
// new/oreg/16, old/no-oreg/12) driven in lockstep against a model.
module tb_sram_dp_core;
    import sram_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init_req = 1'b0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [3:0]  waddr = '0;
    logic [3:0]  raddr = '0;
    logic [3:0]  wbe = '0;
    logic [31:0] wdata = '0;

    logic        busy_w   [3];
    logic        rvalid_w [3];
    logic [31:0] rdata_w  [3];

    always #5 clk = ~clk;

    sram_dp_core #(
        .DATA_W(32), .ADDR_W(4), .DEPTH(16),
        .RDW_MODE(RDW_OLD), .OUT_REG(0)
    ) u0 (
        .clk(clk), .rst_n(rst_n), .init_req(init_req),
        .busy(busy_w[0]), .we(we), .waddr(waddr),
        .wdata(wdata), .wbe(wbe), .re(re), .raddr(raddr),
        .rdata(rdata_w[0]), .rvalid(rvalid_w[0])
    );

    sram_dp_core #(
        .DATA_W(32), .ADDR_W(4), .DEPTH(16),
        .RDW_MODE(RDW_NEW), .OUT_REG(1)
    ) u1 (
        .clk(clk), .rst_n(rst_n), .init_req(init_req),
        .busy(busy_w[1]), .we(we), .waddr(waddr),
        .wdata(wdata), .wbe(wbe), .re(re), .raddr(raddr),
        .rdata(rdata_w[1]), .rvalid(rvalid_w[1])
    );

    sram_dp_core #(
        .DATA_W(32), .ADDR_W(4), .DEPTH(12),
        .RDW_MODE(RDW_OLD), .OUT_REG(0)
    ) u2 (
        .clk(clk), .rst_n(rst_n), .init_req(init_req),
        .busy(busy_w[2]), .we(we), .waddr(waddr),
        .wdata(wdata), .wbe(wbe), .re(re), .raddr(raddr),
        .rdata(rdata_w[2]), .rvalid(rvalid_w[2])
    );

    typedef struct {
        int          k;
        int          due;
        logic [31:0] d;
    } exp_t;

    exp_t        q[$];
    int          dep [3] = '{16, 16, 12};
    int          lat [3] = '{0, 1, 0};
    bit          newm [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] mm [3][16];
    int          rem [3];
    logic [31:0] last [3];
    int          n = 0;
    int          checks = 0;
    int          errors = 0;
    string       tag = "init";

    function automatic logic [31:0] merge(
        logic [31:0] o, logic [31:0] w, logic [3:0] be
    );
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[8*i +: 8] = w[8*i +: 8];
        return r;
    endfunction

    task automatic chk(
        input string what, input int k,
        input logic [31:0] got, input logic [31:0] exp
    );
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s %s dut%0d got %h exp %h",
                   tag, what, k, got, exp);
        end
    endtask

    task automatic check_out();
        for (int k = 0; k < 3; k++) begin
            int f;
            f = -1;
            chk("busy", k, 32'(busy_w[k]), 32'(rem[k] > 0));
            for (int i = 0; i < q.size(); i++)
                if (f < 0 && q[i].k == k) f = i;
            if (f >= 0 && q[f].due == n) begin
                chk("rvalid", k, 32'(rvalid_w[k]), 32'd1);
                chk("rdata", k, rdata_w[k], q[f].d);
                last[k] = q[f].d;
                q.delete(f);
            end else begin
                chk("rvalid", k, 32'(rvalid_w[k]), 32'd0);
                chk("rhold", k, rdata_w[k], last[k]);
            end
        end
    endtask

    task automatic model(
        input logic i_we, input logic [3:0] wa,
        input logic [31:0] wd, input logic [3:0] be,
        input logic i_re, input logic [3:0] ra,
        input logic ini
    );
        for (int k = 0; k < 3; k++) begin
            if (rem[k] > 0) begin
                rem[k]--;
            end else begin
                if (i_re) begin
                    exp_t e;
                    logic [31:0] d;
                    d = (int'(ra) < dep[k]) ? mm[k][ra] : 32'h0;
                    if (newm[k] && i_we && wa == ra
                        && int'(wa) < dep[k])
                        d = merge(d, wd, be);
                    e.k = k;
                    e.due = n + lat[k];
                    e.d = d;
                    q.push_back(e);
                end
                if (i_we && int'(wa) < dep[k])
                    mm[k][wa] = merge(mm[k][wa], wd, be);
                if (ini) begin
                    rem[k] = dep[k];
                    for (int a = 0; a < 16; a++) mm[k][a] = '0;
                end
            end
        end
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic step(
        input logic i_we, input logic [3:0] wa,
        input logic [31:0] wd, input logic [3:0] be,
        input logic i_re, input logic [3:0] ra,
        input logic ini
    );
        we = i_we; waddr = wa; wdata = wd; wbe = be;
        re = i_re; raddr = ra; init_req = ini;
        @(posedge clk);
        n++;
        #1;
        model(i_we, wa, wd, be, i_re, ra, ini);
        check_out();
        @(negedge clk);
    endtask

    task automatic idle(input int c);
        for (int i = 0; i < c; i++)
            step(1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic wr(
        input logic [3:0] a, input logic [31:0] d,
        input logic [3:0] be
    );
        step(1'b1, a, d, be, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic rd(input logic [3:0] a);
        step(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, a, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        we = 1'b0; re = 1'b0; init_req = 1'b0;
        @(posedge clk);
        n++;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_busy", k, 32'(busy_w[k]), 32'd1);
            chk("rst_rvalid", k, 32'(rvalid_w[k]), 32'd0);
            chk("rst_rdata", k, rdata_w[k], 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        for (int k = 0; k < 3; k++) begin
            rem[k] = dep[k];
            last[k] = '0;
            for (int a = 0; a < 16; a++) mm[k][a] = '0;
        end
    endtask

    initial begin
        @(negedge clk);
        tag = "reset";
        do_reset();
        idle(16);

        tag = "read_cleared";
        for (int a = 0; a < 16; a++) rd(4'(a));
        idle(2);

        tag = "byte_enable";
        wr(4'd2, 32'hDEADBEEF, 4'hF);
        wr(4'd2, 32'h000000AA, 4'b0001);
        rd(4'd2);
        idle(2);

        tag = "back_to_back";
        wr(4'd2, 32'd42, 4'hF);
        wr(4'd7, 32'd99, 4'hF);
        wr(4'd0, 32'd13, 4'hF);
        rd(4'd2);
        rd(4'd7);
        rd(4'd0);
        idle(2);

        tag = "rdw";
        wr(4'd5, 32'h11111111, 4'hF);
        step(1'b1, 4'd5, 32'h22222222, 4'b0011, 1'b1, 4'd5, 1'b0);
        rd(4'd5);
        idle(2);

        tag = "init_clear";
        step(1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0, 1'b1);
        for (int i = 0; i < 4; i++)
            step(1'b1, 4'(i), 32'hCAFEF00D, 4'hF, 1'b1, 4'd5, 1'b1);
        idle(12);
        for (int a = 0; a < 16; a++) rd(4'(a));
        idle(2);

        tag = "reset_mid_clear";
        wr(4'd3, 32'h12345678, 4'hF);
        step(1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0, 1'b1);
        idle(6);
        do_reset();
        idle(17);
        rd(4'd3);
        rd(4'd0);
        idle(2);

        tag = "out_of_range";
        wr(4'd13, 32'hFFFFFFFF, 4'hF);
        wr(4'd11, 32'h0, 4'h0);
        rd(4'd13);
        rd(4'd11);
        idle(2);

        tag = "drain";
        chk("queue_empty", 0, 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
